// File: rtl/div_pkg.sv
// Shared definitions for the keypad-to-divider sequencer: state encoding, error pattern, digit count.
// No logic; imported by div_seq_ctrl and div_seq_opreg.
// No flow control of its own.
package div_pkg;

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_START,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  // Wide enough for any supported 2*W display word; users slice the low bits.
  localparam logic [63:0] ERR_PATTERN = {64{1'b1}};

  function automatic int digits(input int w);
    return w / 4;
  endfunction

endpackage

// File: rtl/div_seq_opreg.sv
// Hex digit shift register for one operand, with clear, load-enable and last-digit flag.
// nxt/last are combinational from this cycle's controls; val updates on the next clk.
// No backpressure: every ld is consumed in the cycle it is asserted.
module div_seq_opreg
  import div_pkg::*;
#(
  parameter int W  = 8,
  parameter int ND = W / 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [3:0]   din,
  output logic [W-1:0] val,
  output logic [W-1:0] nxt,
  output logic         last
);

  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [W-1:0]  base;
  logic [CW-1:0] base_cnt;

  // A clear together with a load restarts the operand with din as its first digit.
  always_comb begin
    base     = clr ? '0 : val;
    base_cnt = clr ? '0 : cnt;
    nxt      = base;
    cnt_nxt  = base_cnt;
    last     = 1'b0;
    if (ld) begin
      nxt     = (base << 4) | W'(din);
      last    = (base_cnt == CW'(ND - 1));
      cnt_nxt = last ? '0 : base_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val <= '0;
      cnt <= '0;
    end else begin
      val <= nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Keypad-to-divider sequencer: collects A then B, starts the divider, shows {Q,R} or FFFF on /0.
// Last B digit to div_start 2 cycles; div_done to disp_val 1 cycle. Optional DIV_SEQ_TIMEOUT_EN watchdog.
// Keys and clear are dropped while busy; the divider is never aborted.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int W       = 8,
  parameter int TMO_CYC = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [3:0]     key_code,
  input  logic           key_clr,
  output logic           div_start,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  input  logic           div_done,
  input  logic [W-1:0]   div_q,
  input  logic [W-1:0]   div_r,
  output logic [2*W-1:0] disp_val,
  output logic           busy,
  output logic           err
);

  localparam int ND = digits(W);

  state_t       state;
  logic [W-1:0] q_reg;
  logic [W-1:0] r_reg;
  logic [W-1:0] a_val, a_nxt, b_val, b_nxt;
  logic         a_last, b_last;
  logic         idle, restart, clr_both, a_ld, b_ld;

`ifdef DIV_SEQ_TIMEOUT_EN
  localparam int TC = $clog2(TMO_CYC + 1);
  logic [TC-1:0] tmo_cnt;
`endif

  assign idle     = (state == S_A) || (state == S_B) || (state == S_SHOW) || (state == S_ERR);
  assign restart  = (state == S_SHOW) || (state == S_ERR);
  assign clr_both = idle && (key_clr || (key_valid && restart));
  assign a_ld     = key_valid && !key_clr && ((state == S_A) || restart);
  assign b_ld     = key_valid && !key_clr && (state == S_B);

  div_seq_opreg #(.W(W), .ND(ND)) u_opa (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_both),
    .ld   (a_ld),
    .din  (key_code),
    .val  (a_val),
    .nxt  (a_nxt),
    .last (a_last)
  );

  div_seq_opreg #(.W(W), .ND(ND)) u_opb (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_both),
    .ld   (b_ld),
    .din  (key_code),
    .val  (b_val),
    .nxt  (b_nxt),
    .last (b_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_A;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      disp_val  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
`ifdef DIV_SEQ_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      div_start <= 1'b0;
      case (state)
        S_A: begin
          if (key_clr || key_valid) begin
            disp_val <= {a_nxt, b_nxt};
            if (!key_clr && a_last) state <= S_B;
          end
        end
        S_B: begin
          if (key_clr) begin
            state    <= S_A;
            disp_val <= {a_nxt, b_nxt};
          end else if (key_valid) begin
            if (b_last && (b_nxt == '0)) begin
              state    <= S_ERR;
              err      <= 1'b1;
              disp_val <= ERR_PATTERN[2*W-1:0];
            end else begin
              disp_val <= {a_nxt, b_nxt};
              if (b_last) begin
                state <= S_START;
                busy  <= 1'b1;
              end
            end
          end
        end
        S_START: begin
          div_start <= 1'b1;
          div_a     <= a_val;
          div_b     <= b_val;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            q_reg    <= div_q;
            r_reg    <= div_r;
            disp_val <= {div_q, div_r};
            busy     <= 1'b0;
            state    <= S_SHOW;
`ifdef DIV_SEQ_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
`ifdef DIV_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TC'(TMO_CYC - 1)) begin
            state    <= S_ERR;
            err      <= 1'b1;
            busy     <= 1'b0;
            disp_val <= ERR_PATTERN[2*W-1:0];
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_SHOW, S_ERR: begin
          // Q/R stay latched in q_reg/r_reg; a key here starts a fresh A.
          if (key_clr || key_valid) begin
            state    <= S_A;
            err      <= 1'b0;
            disp_val <= {a_nxt, b_nxt};
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencer between the keypad decoder and the divider datapath in top_divisor.
- Collects a two-digit hex dividend A, then a two-digit hex divisor B.
- Pulses start to the divider, waits for done, latches quotient and remainder, and drives the 16-bit value shown on the 4-digit seven-segment display.
- Traps divide-by-zero without starting the divider.

Parameters:
- W, 8, operand/result width in bits; must be a multiple of 4.
- ND, W/4, hex digits per operand (derived; do not override).
- TMO_CYC, 1024, divider watchdog limit in clk cycles (used only with DIV_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous active-low reset.
- key_valid  in  1  one-cycle pulse per debounced key press.
- key_code  in  4  hex value of the pressed key; sampled only when key_valid=1.
- key_clr  in  1  one-cycle clear-command pulse from the keypad.
- div_start  out  1  one-cycle start pulse to the divider.
- div_a  out  W  dividend to the divider; held stable from div_start until div_done.
- div_b  out  W  divisor to the divider; held stable from div_start until div_done.
- div_done  in  1  divider completion pulse (level is also accepted).
- div_q  in  W  quotient; valid in the cycle div_done=1.
- div_r  in  W  remainder; valid in the cycle div_done=1.
- disp_val  out  2W  value to the display driver: upper half = A or Q, lower half = B or R.
- busy  out  1  high in S_START and S_WAIT.
- err  out  1  high in S_ERR.

Behaviour:
- Reset (rst=0 at posedge clk):
  - state=S_A, digit counter=0.
  - A, B, Q, R registers=0.
  - div_start=0, busy=0, err=0, disp_val=0.
- Shared state encoding lives in div_pkg: S_A, S_B, S_START, S_WAIT, S_SHOW, S_ERR.
- S_A, on key_valid:
  - A <= {A[W-5:0], key_code}; cnt++.
  - When cnt reaches ND-1 on that press: cnt<=0, go to S_B.
- S_B, on key_valid:
  - B is shifted in the same way.
  - On the last digit: go to S_ERR if the resulting B==0, else S_START.
- Register output: disp_val={A,B} in S_A and S_B, updated the cycle after each key.
- S_START:
  - div_start=1 for exactly one cycle.
  - div_a=A, div_b=B, registered.
  - Next state is S_WAIT.
- S_WAIT:
  - Hold div_start=0.
  - On div_done=1: Q<=div_q, R<=div_r, go to S_SHOW.
- S_SHOW:
  - disp_val={Q,R}.
  - The next key_valid clears A and B and loads key_code as the first digit of the new A (state S_A, cnt=1).
- S_ERR:
  - disp_val = all ones (2W'hFFFF... pattern, shown as "FFFF").
  - Any key_valid or key_clr goes to S_A with A=B=0.
- key_clr in S_A, S_B, S_SHOW or S_ERR: A=B=0, cnt=0, state=S_A. key_clr has priority over a simultaneous key_valid.
- key_valid and key_clr are ignored while busy. The divider is never aborted mid-operation.
- div_done outside S_WAIT is ignored; Q and R are unchanged.
- Latency:
  - Last B digit to div_start = 2 cycles (S_B -> S_START registered output).
  - div_done to disp_val update = 1 cycle.
- Reset asserted mid-division returns to reset values. Any late div_done is ignored.

Optional Feature:
- Macro: DIV_SEQ_TIMEOUT_EN.
- When defined:
  - A counter runs in S_WAIT.
  - If it reaches TMO_CYC without div_done: go to S_ERR with disp_val=all ones.
  - The counter clears on leaving S_WAIT.
- When undefined:
  - No counter is instantiated.
  - S_WAIT waits indefinitely.

Decomposition:
- div_pkg:
  - state enum.
  - ERR_PATTERN constant (all ones).
  - a function returning the digit count from W.
- One sub-module: div_seq_opreg.
  - A W-bit hex digit shift register with clear, load-enable and a last-digit flag.
  - Instantiated twice, once for A and once for B.

Test Plan:
- Keys 4,5,0,7 (W=8) -> div_start pulses once, div_a=0x45, div_b=0x07.
  - Model divider returns done with q=9, r=6 -> disp_val=16'h0906 one cycle after done, busy=0.
- Keys 1,2,0,0 -> no div_start; err=1, disp_val=16'hFFFF.
  - Then key 3 -> state S_A, disp_val=16'h0300.
- Keys 4, key_clr, 8,1,0,3 -> div_a=0x81, div_b=0x03 (the 4 is discarded).
  - key_clr and key_valid in the same cycle -> clear wins.
- Keys pressed while busy -> ignored: div_a and div_b stay stable, no second div_start.
  - A spurious div_done in S_SHOW leaves disp_val unchanged.
- rst=0 in S_WAIT, then done arrives -> all outputs stay 0, state S_A.
- With DIV_SEQ_TIMEOUT_EN and TMO_CYC=16, divider never completes -> err=1 exactly 16 cycles after entering S_WAIT.
